// File: rtl/up_sample.sv
// rtl/up_sample.sv - sample-rate doubler (repeat or zero-fill) with pass-through mode
//
// Purpose: accepts one sample per input handshake and emits it once
// (pass-through) or twice (upsample). In upsample mode the second copy is
// either a repeat or zero, chosen by zero_fill at the time of the accept.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   en_upsample  1 = emit each sample twice, 0 = pass-through
//   zero_fill    upsample mode: second copy is zero instead of a repeat
//   data_in      upstream sample
//   valid_in     upstream sample valid
//   in_ready     block accepts data_in this cycle (combinational)
//   data_out     registered output sample
//   valid_out    registered output valid
//   out_ready    downstream accepts data_out this cycle
//   out_count    number of completed output handshakes (wraps)
module up_sample #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_upsample,
  input  logic              zero_fill,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              valid_in,
  output logic              in_ready,
  output logic [DWIDTH-1:0] data_out,
  output logic              valid_out,
  input  logic              out_ready,
  output logic [CWIDTH-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DWIDTH-1:0]   data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;
  logic [DWIDTH-1:0]   sample_q, sample_d;
  logic                dup_q, dup_d;
  logic                zf_q, zf_d;
  logic [CWIDTH-1:0]   count_q, count_d;

  logic accept;
  logic out_hs;

  // A new sample can enter only when the current one has nothing left to
  // present after this cycle's handshake, which keeps the output gap-free.
  assign in_ready = (state_q == IDLE)
                  | ((state_q == FIRST) & ~dup_q & out_ready)
                  | ((state_q == SECOND) & out_ready);

  assign accept = valid_in & in_ready;
  assign out_hs = valid_out_q & out_ready;

  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    sample_d    = sample_q;
    dup_d       = dup_q;
    zf_d        = zf_q;
    count_d     = out_hs ? count_q + CWIDTH'(1) : count_q;

    case (state_q)
      IDLE: ;
      FIRST: begin
        if (out_hs) begin
          if (dup_q) begin
            state_d    = SECOND;
            data_out_d = zf_q ? '0 : sample_q;
          end else begin
            state_d     = IDLE;
            valid_out_d = 1'b0;
          end
        end
      end
      SECOND: begin
        if (out_hs) begin
          state_d     = IDLE;
          valid_out_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        valid_out_d = 1'b0;
      end
    endcase

    // An accept only happens when the current beat (if any) finishes this
    // cycle, so loading the new sample overrides the drain-to-IDLE above.
    // The mode is captured here so a pair completes in its own mode.
    if (accept) begin
      state_d     = FIRST;
      data_out_d  = data_in;
      valid_out_d = 1'b1;
      sample_d    = data_in;
      dup_d       = en_upsample;
      zf_d        = zero_fill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      sample_q    <= '0;
      dup_q       <= 1'b0;
      zf_q        <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      sample_q    <= sample_d;
      dup_q       <= dup_d;
      zf_q        <= zf_d;
      count_q     <= count_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_up_sample.sv
// tb/tb_up_sample.sv - self-checking bench for up_sample
module tb_up_sample;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          en_upsample;
  logic          zero_fill;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          in_ready;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          out_ready;
  logic [CW-1:0] out_count;

  up_sample #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .en_upsample (en_upsample),
    .zero_fill   (zero_fill),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .out_ready   (out_ready),
    .out_count   (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          en;
    logic          zf;
    logic          ordy;
    logic          exp_rdy;
    logic          exp_vld;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] sb[$];
  logic [CW-1:0] cnt;
  int            n_vec = 0;
  int            n_err = 0;
  logic          last_rdy, last_vld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic v, input logic [DW-1:0] d, input logic en,
                              input logic zf, input logic ordy, input logic er, input logic ev);
    vec_t r;
    r.v = v; r.d = d; r.en = en; r.zf = zf; r.ordy = ordy; r.exp_rdy = er; r.exp_vld = ev;
    tbl.push_back(r);
  endfunction

  // One clock: drive on the falling edge, check against the scoreboard model,
  // then advance the model by the handshakes that the rising edge will take.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic en,
                      input logic zf, input logic ordy);
    logic er, ev;
    @(negedge clk);
    reset = 1'b0; valid_in = v; data_in = d; en_upsample = en; zero_fill = zf; out_ready = ordy;
    #1;
    er = (sb.size() == 0) || (sb.size() == 1 && ordy);
    ev = (sb.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("valid_out", 32'(valid_out), 32'(ev));
    if (ev) chk("data_out", 32'(data_out), 32'(sb[0]));
    chk("out_count", 32'(out_count), 32'(cnt));
    last_rdy = in_ready;
    last_vld = valid_out;
    if (ev && ordy) begin
      void'(sb.pop_front());
      cnt = cnt + 1'b1;
    end
    if (v && er) begin
      sb.push_back(d);
      if (en) sb.push_back(zf ? '0 : d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() != 0; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0; en_upsample = 1'b0;
    zero_fill = 1'b0; out_ready = 1'b0; cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    // repeat mode, back-to-back 0x12, 0x34: in_ready 1,0,1,0
    add(1, 8'h12, 1, 0, 1, 1, 0);
    add(1, 8'h34, 1, 0, 1, 0, 1);
    add(1, 8'h34, 1, 0, 1, 1, 1);
    add(0, 8'h00, 1, 0, 1, 0, 1);
    add(0, 8'h00, 1, 0, 1, 1, 1);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    // zero-fill 0x7F
    add(1, 8'h7F, 1, 1, 1, 1, 0);
    add(0, 8'h00, 1, 1, 1, 0, 1);
    add(0, 8'h00, 1, 1, 1, 1, 1);
    // pass-through 0x01..0x08
    add(1, 8'h01, 0, 0, 1, 1, 0);
    for (int i = 2; i <= 8; i++) add(1, 8'(i), 0, 0, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 1, 0);
    // 0xA5 with stalls in FIRST and SECOND; 0x99 offered while stalled is ignored
    add(1, 8'hA5, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 0, 1);
    add(0, 8'h00, 1, 0, 0, 0, 1);
    add(0, 8'h00, 1, 0, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, 0, 1);
    add(1, 8'h99, 1, 0, 0, 0, 1);
    add(1, 8'h99, 1, 0, 0, 0, 1);
    add(0, 8'h00, 1, 0, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, 1, 1);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    // mode change right after accepting 0x55
    add(1, 8'h55, 1, 0, 1, 1, 0);
    add(1, 8'h66, 0, 0, 1, 0, 1);
    add(1, 8'h66, 0, 0, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].en, tbl[i].zf, tbl[i].ordy);
      chk("tbl_in_ready", 32'(last_rdy), 32'(tbl[i].exp_rdy));
      chk("tbl_valid_out", 32'(last_vld), 32'(tbl[i].exp_vld));
    end
    chk("total_count", 32'(out_count), 32'd19);

    // counter wrap: stream pass-through beats until the count reaches all-ones
    for (int i = 0; i < 600 && cnt != '1; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("wrap_zero", 32'(out_count), 32'd0);
    drain();
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // reset while SECOND holds 0x3C
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1; valid_in = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("midpair_valid", 32'(valid_out), 32'd0);
    chk("midpair_count", 32'(out_count), 32'd0);
    chk("midpair_data", 32'(data_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    cnt = '0;
    #1;
    chk("midpair_ready", 32'(in_ready), 32'd1);
    repeat (4) step(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("final_count", 32'(out_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
